// File: rtl/mdu_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
// Op codes and FSM state type used by mdu_iter and its bench.
package mdu_pkg;

  localparam logic [1:0] MDU_MULT  = 2'b00;
  localparam logic [1:0] MDU_MULTU = 2'b01;
  localparam logic [1:0] MDU_DIV   = 2'b10;
  localparam logic [1:0] MDU_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_e;

endpackage

// File: rtl/mdu_addsub.sv
// WIDTH+1-bit adder/subtractor shared by the multiply accumulate
// and the restoring-divide trial subtract.
module mdu_addsub #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0] x,
  input  logic [WIDTH:0] y,
  input  logic           sub,
  output logic [WIDTH:0] sum,
  output logic           cout
);

  logic [WIDTH:0] yEff;

  assign yEff = sub ? ~y : y;

  // cout = 1 on subtract means no borrow
  assign {cout, sum} = {1'b0, x} + {1'b0, yEff}
                     + {{(WIDTH + 1){1'b0}}, sub};

endmodule

// File: rtl/mdu_iter.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers,
// one result bit per cycle, flush and hazard stall support.
module mdu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  input  logic             use_req,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic             stall
);

  import mdu_pkg::*;

  localparam int CW = $clog2(WIDTH + 1);

  state_e state, stateNext;
  logic load, step, commit;

  logic [CW-1:0]    count;
  logic [WIDTH-1:0] accHi, accLo, opnd;
  logic             isDiv, negRes, negRem, byZero;

  logic             opDiv, opSigned;
  logic             signA, signB;
  logic [WIDTH-1:0] absA, absB;

  logic [WIDTH:0]   addX, addY, addSum;
  logic             addCout;

  logic [2*WIDTH-1:0] prod, prodFix;
  logic [WIDTH-1:0]   quo, rem, hiNew, loNew;

  logic [WIDTH-1:0] hiQ, loQ;
  logic             doneQ, divZeroQ;

  always_comb begin
    opDiv    = 1'b0;
    opSigned = 1'b0;
    unique case (op)
      MDU_MULT:  opSigned = 1'b1;
      MDU_MULTU: opSigned = 1'b0;
      MDU_DIV: begin
        opDiv    = 1'b1;
        opSigned = 1'b1;
      end
      MDU_DIVU:  opDiv = 1'b1;
    endcase
  end

  assign signA = opSigned & a[WIDTH-1];
  assign signB = opSigned & b[WIDTH-1];
  assign absA  = signA ? -a : a;
  assign absB  = signB ? -b : b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    load      = 1'b0;
    step      = 1'b0;
    commit    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && !flush) begin
          load      = 1'b1;
          stateNext = CALC;
        end
      end
      CALC: begin
        if (flush) begin
          stateNext = IDLE;
        end else begin
          step = 1'b1;
          if (count == CW'(1)) stateNext = FIX;
        end
      end
      FIX: begin
        stateNext = IDLE;
        commit    = !flush;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Divide: {rem, next dividend bit} - divisor.
  // Multiply: hi half + multiplicand when the low bit is set.
  assign addX = isDiv ? {accHi, accLo[WIDTH-1]}
                      : {1'b0, accHi};
  assign addY = {1'b0, opnd & {WIDTH{isDiv | accLo[0]}}};

  mdu_addsub #(
    .WIDTH(WIDTH)
  ) uAddSub (
    .x   (addX),
    .y   (addY),
    .sub (isDiv),
    .sum (addSum),
    .cout(addCout)
  );

  assign prod    = {accHi, accLo};
  assign prodFix = negRes ? -prod : prod;
  // By zero the remainder path naturally rebuilds the dividend
  assign quo     = byZero ? '1 : (negRes ? -accLo : accLo);
  assign rem     = negRem ? -accHi : accHi;
  assign hiNew   = isDiv ? rem : prodFix[2*WIDTH-1:WIDTH];
  assign loNew   = isDiv ? quo : prodFix[WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= '0;
      accHi    <= '0;
      accLo    <= '0;
      opnd     <= '0;
      isDiv    <= 1'b0;
      negRes   <= 1'b0;
      negRem   <= 1'b0;
      byZero   <= 1'b0;
      hiQ      <= '0;
      loQ      <= '0;
      doneQ    <= 1'b0;
      divZeroQ <= 1'b0;
    end else begin
      doneQ <= commit;
      if (load) begin
        count  <= CW'(WIDTH);
        accHi  <= '0;
        accLo  <= opDiv ? absA : absB;
        opnd   <= opDiv ? absB : absA;
        isDiv  <= opDiv;
        negRes <= signA ^ signB;
        negRem <= signA;
        byZero <= opDiv & (b == '0);
      end else if (step) begin
        count <= count - CW'(1);
        if (isDiv) begin
          accHi <= addCout ? addSum[WIDTH-1:0]
                           : addX[WIDTH-1:0];
          accLo <= {accLo[WIDTH-2:0], addCout};
        end else begin
          accHi <= addSum[WIDTH:1];
          accLo <= {addSum[0], accLo[WIDTH-1:1]};
        end
      end
      if (commit) begin
        hiQ      <= hiNew;
        loQ      <= loNew;
        divZeroQ <= byZero;
      end else if (state == IDLE && !start) begin
        if (mthi) hiQ <= wdata;
        if (mtlo) loQ <= wdata;
      end
    end
  end

  assign hi       = hiQ;
  assign lo       = loQ;
  assign busy     = (state != IDLE);
  assign done     = doneQ;
  assign div_zero = divZeroQ;
  assign stall    = busy & use_req;

endmodule

// File: tb/tb_mdu_iter.sv
// Directed bench for mdu_iter: vector table plus flush,
// busy-start, mthi/mtlo and async reset sequences.
module tb_mdu_iter;
  import mdu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         flush = 1'b0;
  logic         mthi = 1'b0;
  logic         mtlo = 1'b0;
  logic [W-1:0] wdata = '0;
  logic         use_req = 1'b0;
  logic [W-1:0] hi, lo;
  logic         busy, done, div_zero, stall;

  int checks = 0;
  int failures = 0;

  mdu_iter #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .flush   (flush),
    .mthi    (mthi),
    .mtlo    (mtlo),
    .wdata   (wdata),
    .use_req (use_req),
    .hi      (hi),
    .lo      (lo),
    .busy    (busy),
    .done    (done),
    .div_zero(div_zero),
    .stall   (stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int           mid;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name,
                       input logic [W-1:0] act,
                       input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue at a negedge; returns at the negedge where done is seen.
  // lat counts posedges after the start edge.
  task automatic runOp(input logic [1:0] o,
                       input logic [W-1:0] x,
                       input logic [W-1:0] y,
                       input int midStart,
                       output int lat,
                       output int busyCycles);
    op = o;
    a = x;
    b = y;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    busyCycles = busy ? 1 : 0;
    while (!done && lat < 100) begin
      if (lat == midStart) begin
        start = 1'b1;
        op = MDU_DIVU;
        a = 32'h0000_0064;
        b = 32'h0000_0001;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
      if (busy) busyCycles++;
    end
    start = 1'b0;
  endtask

  initial begin
    int lat, bc, doneSeen;

    vecs[0] = '{MDU_MULT,  32'hFFFFFFFF, 32'h00000007,
                32'hFFFFFFFF, 32'hFFFFFFF9, 1'b0, -1};
    vecs[1] = '{MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF,
                32'hFFFFFFFE, 32'h00000001, 1'b0, 5};
    vecs[2] = '{MDU_DIV,   32'hFFFFFFF9, 32'h00000002,
                32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, -1};
    vecs[3] = '{MDU_DIVU,  32'h00000007, 32'h00000002,
                32'h00000001, 32'h00000003, 1'b0, -1};
    vecs[4] = '{MDU_DIV,   32'h80000000, 32'hFFFFFFFF,
                32'h00000000, 32'h80000000, 1'b0, -1};
    vecs[5] = '{MDU_MULT,  32'hFFFFFFFD, 32'hFFFFFFFB,
                32'h00000000, 32'h0000000F, 1'b0, -1};
    vecs[6] = '{MDU_DIV,   32'h00000007, 32'hFFFFFFFE,
                32'h00000001, 32'hFFFFFFFD, 1'b0, -1};
    vecs[7] = '{MDU_DIV,   32'hFFFFFFF8, 32'h00000000,
                32'hFFFFFFF8, 32'hFFFFFFFF, 1'b1, -1};
    vecs[8] = '{MDU_MULTU, 32'h00010000, 32'h00010000,
                32'h00000001, 32'h00000000, 1'b0, -1};
    vecs[9] = '{MDU_DIVU,  32'h00000005, 32'h00000000,
                32'h00000005, 32'hFFFFFFFF, 1'b1, -1};

    #12;
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_done", {31'b0, done}, 32'h0);
    check("rst_dz", {31'b0, div_zero}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Rows run back to back: each start lands in the done cycle
    for (int i = 0; i < 10; i++) begin
      runOp(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].mid, lat, bc);
      check($sformatf("v%0d_lat", i), 32'(lat), 32'd33);
      check($sformatf("v%0d_hi", i), hi, vecs[i].hi);
      check($sformatf("v%0d_lo", i), lo, vecs[i].lo);
      check($sformatf("v%0d_dz", i), {31'b0, div_zero},
            {31'b0, vecs[i].dz});
      if (i == 0) check("v0_busy_cycles", 32'(bc), 32'd33);
    end
    @(negedge clk);
    check("done_pulse_end", {31'b0, done}, 32'h0);

    // Flush sequence
    mthi = 1'b1;
    wdata = 32'h0000_1234;
    @(negedge clk);
    mthi = 1'b0;
    mtlo = 1'b1;
    wdata = 32'h0000_5678;
    @(negedge clk);
    mtlo = 1'b0;
    check("mthi_val", hi, 32'h0000_1234);
    check("mtlo_val", lo, 32'h0000_5678);

    op = MDU_MULTU;
    a = 32'h3;
    b = 32'h3;
    start = 1'b1;
    use_req = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("stall_busy", {31'b0, stall}, 32'h1);
    check("busy_on", {31'b0, busy}, 32'h1);
    for (int k = 1; k < 10; k++) begin
      mtlo = (k == 3);
      wdata = 32'h0000_DEAD;
      @(negedge clk);
    end
    mtlo = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", {31'b0, busy}, 32'h0);
    check("flush_done", {31'b0, done}, 32'h0);
    check("flush_stall", {31'b0, stall}, 32'h0);
    doneSeen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) doneSeen++;
    end
    use_req = 1'b0;
    check("flush_no_done", 32'(doneSeen), 32'h0);
    check("flush_hi", hi, 32'h0000_1234);
    check("flush_lo", lo, 32'h0000_5678);
    check("flush_dz", {31'b0, div_zero}, 32'h1);

    // Async reset mid-divide
    op = MDU_DIV;
    a = 32'd100;
    b = 32'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    check("pre_rst_busy", {31'b0, busy}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_hi", hi, 32'h0);
    check("arst_lo", lo, 32'h0);
    check("arst_busy", {31'b0, busy}, 32'h0);
    check("arst_done", {31'b0, done}, 32'h0);
    check("arst_dz", {31'b0, div_zero}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mtlo = 1'b1;
    wdata = 32'hA5A5_A5A5;
    @(negedge clk);
    mtlo = 1'b0;
    check("post_rst_mtlo", lo, 32'hA5A5_A5A5);
    check("post_rst_hi", hi, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mdu_iter.md
# mdu_iter

Iterative, parametrised multiply/divide unit with architectural HI/LO registers for the pipelined MIPS core. It executes MULT, MULTU, DIV and DIVU over a configurable operand width and processes one result bit per cycle. It sits beside the execute-stage ALU, takes operands from the forwarded execute-stage sources, and produces a stall request for the hazard unit while a result is pending. A flush input cancels an in-flight operation when the issuing instruction is squashed.

## Interface
- WIDTH, 32, operand and HI/LO width; must be ≥ 4.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  issue request, sampled on clk; op, a and b are valid in the same cycle.
- op  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- a, b  in  WIDTH  multiplicand/dividend (a) and multiplier/divisor (b).
- flush  in  1  abort any in-flight operation.
- mthi, mtlo  in  1  write wdata to HI or LO.
- wdata  in  WIDTH  data for mthi/mtlo.
- use_req  in  1  decode-stage instruction reads or writes HI/LO or issues to the unit.
- hi, lo  out  WIDTH  architectural HI/LO registers.
- busy  out  1  operation in flight.
- done  out  1  one-cycle pulse in the cycle after HI/LO update.
- div_zero  out  1  registered flag for the last completed divide: set when the divisor was 0.
- stall  out  1  combinational: busy & use_req.

## Operation
- FSM states:
  - IDLE: a sampled start with no flush latches |a|, |b|, the result signs and the op, sets count = WIDTH, and moves to CALC.
  - CALC: one step per edge, count decrements; when count reaches 1, moves to FIX.
  - FIX: applies sign correction, writes HI/LO, pulses done, returns to IDLE.
- Multiply: shift-add over a 2·WIDTH accumulator.
  - Signed product is negated (2·WIDTH two's complement) when sign(a) ≠ sign(b).
  - HI = product[2W-1:W], LO = product[W-1:0].
- Divide: restoring, using a WIDTH+1-bit subtractor.
  - LO = quotient, HI = remainder.
  - Signed: the quotient is negated when the signs differ; the remainder takes the sign of the dividend.
- Divide by zero: the iteration runs normally with full latency.
  - Forced result: LO = all ones, HI = a (original, unmodified).
  - div_zero = 1 at FIX; any other completion clears it.
- Signed overflow (min / −1): no special path; the natural result is LO = min, HI = 0.
- start while busy: ignored; no queueing.
- mthi/mtlo:
  - Honoured only in IDLE without start.
  - In the same cycle as start, the write is dropped.
  - While busy, the write is dropped; the hazard unit guarantees it via stall.
- flush:
  - In CALC or FIX: next state is IDLE, no done, HI/LO and div_zero unchanged.
  - In IDLE with start: the start is ignored.
  - flush has priority over the FIX write.

## Timing
- Reset values: hi = 0, lo = 0, busy = 0, done = 0, div_zero = 0, state IDLE.
  - Reset is asynchronous and aborts any operation mid-flight.
- Latency:
  - start sampled at edge E0; busy is high from after E0.
  - HI/LO are written at edge E(WIDTH+1); busy falls and done rises at that same edge.
  - For WIDTH = 32, HI/LO are valid 33 edges after the start edge.
- Back-to-back: a new start is accepted in the cycle done is high, i.e. the cycle after FIX.
- mthi/mtlo: the new value is visible the cycle after the write edge.
- stall is purely combinational and has no registered delay.

## Structure
- Package mdu_pkg holds:
  - the op encoding constants (MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU);
  - the FSM state enum (IDLE, CALC, FIX).
- One sub-module, mdu_addsub: a WIDTH+1-bit adder/subtractor shared by the multiply accumulate and the divide trial-subtract.
  - The counter, the FSM and the sign fixup stay in mdu_iter.

## Test plan
- MULT a = 0xFFFFFFFF, b = 7 -> hi = 0xFFFFFFFF, lo = 0xFFFFFFF9; done exactly 33 edges after start; busy high for 33 cycles.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> hi = 0xFFFFFFFE, lo = 0x00000001; a second start issued mid-operation is ignored and the result is unchanged.
- DIV −7/2 -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
- DIVU 7/2 -> lo = 3, hi = 1.
- DIV 0x80000000 / 0xFFFFFFFF -> lo = 0x80000000, hi = 0, div_zero = 0.
- DIVU 5/0 -> lo = 0xFFFFFFFF, hi = 5, div_zero = 1.
- Flush path:
  - Preload with mthi 0x1234 and mtlo 0x5678.
  - Start MULTU and assert flush on the 10th cycle.
  - Required: no done, hi/lo still 0x1234/0x5678, busy low on the next cycle.
  - With use_req = 1 while busy, stall = 1.
- Reset path:
  - Drop rst_n low mid-DIV -> hi, lo, busy, done and div_zero go to 0 immediately.
  - After release, mtlo 0xA5A5A5A5 -> lo = 0xA5A5A5A5 on the next cycle.
